// File: rtl/seq_detect_arbiter_if.sv
// Bus between the request channels and the pattern-detector arbiter.
// The master side drives requests and operands; the slave side returns grant and results.
interface seq_detect_arbiter_if #(
    parameter int FRAME_W = 8,
    parameter int PAT_W   = 4
);
    logic [3:0]           req;
    logic [4*FRAME_W-1:0] frame_data;
    logic [PAT_W-1:0]     pattern;
    logic [3:0]           grant;
    logic                 busy;
    logic                 done;
    logic [1:0]           done_id;
    logic [3:0]           match_count;

    modport master (
        output req, frame_data, pattern,
        input  grant, busy, done, done_id, match_count
    );

    modport slave (
        input  req, frame_data, pattern,
        output grant, busy, done, done_id, match_count
    );
endinterface

// File: rtl/seq_detect_arbiter.sv
// Four-channel round-robin arbiter feeding one serial pattern detector.
// Each granted frame is shifted MSB first and overlapping pattern hits are counted.
module seq_detect_arbiter #(
    parameter int FRAME_W = 8,
    parameter int PAT_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    seq_detect_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         rr_ptr_reg, rr_ptr_next;
    logic [1:0]         served_reg, served_next;
    logic [3:0]         grant_reg, grant_next;
    logic [FRAME_W-1:0] frame_reg, frame_next;
    logic [PAT_W-1:0]   pat_reg, pat_next;
    logic [PAT_W-1:0]   window_reg, window_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [3:0]         count_reg, count_next;
    logic [3:0]         match_count_reg, match_count_next;
    logic [1:0]         done_id_reg, done_id_next;

    logic [FRAME_W-1:0] frame_arr [4];
    logic [3:0]         sel_onehot;
    logic [1:0]         sel_id;
    logic               sel_valid;
    logic [PAT_W-1:0]   window_shift;
    logic               hit;
    logic [3:0]         count_inc;
    logic               last_bit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            assign frame_arr[gi]  = bus.frame_data[FRAME_W*gi +: FRAME_W];
            assign sel_onehot[gi] = (sel_id == gi[1:0]);
        end
    endgenerate

    // Round-robin search: the lowest offset from rr_ptr with a pending request wins.
    always_comb begin
        logic [1:0] idx;
        idx       = 2'd0;
        sel_id    = rr_ptr_reg;
        sel_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr_reg + 2'(k);
            if (bus.req[idx]) begin
                sel_id    = idx;
                sel_valid = 1'b1;
            end
        end
    end

    // Window update and overlap-aware hit detection for the bit being shifted this cycle.
    assign window_shift = {window_reg[PAT_W-2:0], frame_reg[FRAME_W-1]};
    assign hit          = (bit_cnt_reg >= CNT_W'(PAT_W-1)) && (window_shift == pat_reg);
    assign count_inc    = (hit && count_reg != 4'hF) ? count_reg + 4'd1 : count_reg;
    assign last_bit     = (bit_cnt_reg == CNT_W'(FRAME_W-1));

    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        served_next      = served_reg;
        grant_next       = grant_reg;
        frame_next       = frame_reg;
        pat_next         = pat_reg;
        window_next      = window_reg;
        bit_cnt_next     = bit_cnt_reg;
        count_next       = count_reg;
        match_count_next = match_count_reg;
        done_id_next     = done_id_reg;

        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    state_next   = SHIFT;
                    served_next  = sel_id;
                    grant_next   = sel_onehot;
                    frame_next   = frame_arr[sel_id];
                    pat_next     = bus.pattern;
                    window_next  = '0;
                    bit_cnt_next = '0;
                    count_next   = 4'd0;
                end
            end
            SHIFT: begin
                frame_next   = frame_reg << 1;
                window_next  = window_shift;
                bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                count_next   = count_inc;
                if (last_bit) begin
                    state_next       = REPORT;
                    match_count_next = count_inc;
                    done_id_next     = served_reg;
                end
            end
            REPORT: begin
                state_next  = IDLE;
                grant_next  = 4'd0;
                rr_ptr_next = served_reg + 2'd1;
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg      <= 2'd0;
            served_reg      <= 2'd0;
            grant_reg       <= 4'd0;
            frame_reg       <= '0;
            pat_reg         <= '0;
            window_reg      <= '0;
            bit_cnt_reg     <= '0;
            count_reg       <= 4'd0;
            match_count_reg <= 4'd0;
            done_id_reg     <= 2'd0;
        end else begin
            rr_ptr_reg      <= rr_ptr_next;
            served_reg      <= served_next;
            grant_reg       <= grant_next;
            frame_reg       <= frame_next;
            pat_reg         <= pat_next;
            window_reg      <= window_next;
            bit_cnt_reg     <= bit_cnt_next;
            count_reg       <= count_next;
            match_count_reg <= match_count_next;
            done_id_reg     <= done_id_next;
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == REPORT);
    assign bus.done_id     = done_id_reg;
    assign bus.match_count = match_count_reg;
endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scenario bench for seq_detect_arbiter: a result scoreboard is filled when frames are
// launched and drained on each done pulse.
module tb_seq_detect_arbiter;
    localparam int FW = 8;
    localparam int PW = 4;

    logic clk;
    logic reset;

    seq_detect_arbiter_if #(.FRAME_W(FW), .PAT_W(PW)) bus ();

    seq_detect_arbiter #(.FRAME_W(FW), .PAT_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [3:0] model_count(input logic [FW-1:0] f, input logic [PW-1:0] p);
        int n;
        n = 0;
        for (int s = FW - 1; s >= PW - 1; s--) begin
            if (f[s -: PW] == p) n++;
        end
        if (n > 15) n = 15;
        return 4'(n);
    endfunction

    task automatic set_frame(input int ch, input logic [FW-1:0] val);
        bus.frame_data[ch*FW +: FW] = val;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [FW-1:0] f, input logic [PW-1:0] p);
        exp_t e;
        e.id  = id;
        e.cnt = model_count(f, p);
        sb.push_back(e);
    endtask

    // Waits on negedges until done is seen or the budget runs out; no checking here.
    task automatic wait_done(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        bus.req        = 4'd0;
        bus.frame_data = '0;
        bus.pattern    = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.grant !== 4'd0) begin failures++; $display("FAIL reset_grant got=%b want=0000", bus.grant); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++;
        if (bus.done_id !== 2'd0 || bus.match_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_result got id=%0d cnt=%0d want id=0 cnt=0", bus.done_id, bus.match_count);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
        $display("test_reset done");
    endtask

    task automatic test_overlap();
        exp_t e;
        bus.pattern = 4'b1011;
        set_frame(0, 8'b10111011);
        bus.req = 4'b0001;
        push_exp(2'd0, 8'b10111011, 4'b1011);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.req = 4'b0000;
            checks++;
            if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL overlap_grant cycle=%0d got grant=%b busy=%b want 0001/1", cyc, bus.grant, bus.busy);
            end
            checks++;
            if (bus.done !== (cyc == 9)) begin
                failures++;
                $display("FAIL overlap_done_timing cycle=%0d got=%b want=%b", cyc, bus.done, (cyc == 9));
            end
            if (bus.done === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.done_id !== e.id || bus.match_count !== e.cnt) begin
                    failures++;
                    $display("FAIL overlap_result got id=%0d cnt=%0d want id=%0d cnt=%0d",
                             bus.done_id, bus.match_count, e.id, e.cnt);
                end
                $display("overlap done id=%0d cnt=%0d", bus.done_id, bus.match_count);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL overlap_idle got grant=%b busy=%b done=%b want 0000/0/0", bus.grant, bus.busy, bus.done);
        end
        checks++;
        if (bus.match_count !== 4'd2 || bus.done_id !== 2'd0) begin
            failures++;
            $display("FAIL overlap_hold got id=%0d cnt=%0d want id=0 cnt=2", bus.done_id, bus.match_count);
        end
    endtask

    task automatic test_saturation();
        logic [FW-1:0] frames [2];
        logic [PW-1:0] pats   [2];
        int            chans  [2];
        bit            seen;
        int            cyc;
        exp_t          e;
        frames[0] = 8'hFF; pats[0] = 4'hF;    chans[0] = 3;
        frames[1] = 8'h00; pats[1] = 4'b1011; chans[1] = 1;
        for (int t = 0; t < 2; t++) begin
            set_frame(chans[t], frames[t]);
            bus.pattern = pats[t];
            bus.req     = 4'(1 << chans[t]);
            push_exp(2'(chans[t]), frames[t], pats[t]);
            @(negedge clk);
            bus.req = 4'd0;
            wait_done(20, seen, cyc);
            checks++;
            if (!seen || cyc + 1 != 9) begin
                failures++;
                $display("FAIL sat_latency case=%0d got seen=%0d cycle=%0d want cycle=9", t, seen, cyc + 1);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.done_id !== e.id || bus.match_count !== e.cnt) begin
                    failures++;
                    $display("FAIL sat_result case=%0d got id=%0d cnt=%0d want id=%0d cnt=%0d",
                             t, bus.done_id, bus.match_count, e.id, e.cnt);
                end
            end
            $display("saturation case=%0d id=%0d cnt=%0d", t, bus.done_id, bus.match_count);
            @(negedge clk);
        end
    endtask

    task automatic test_fairness();
        logic [FW-1:0] frames [4];
        bit            seen;
        int            cyc;
        exp_t          e;
        frames[0] = 8'b10111011;
        frames[1] = 8'b00001011;
        frames[2] = 8'hFF;
        frames[3] = 8'b10110110;
        reset = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) set_frame(c, frames[c]);
        bus.pattern = 4'b1011;
        bus.req     = 4'b1111;
        for (int k = 0; k < 5; k++) push_exp(2'(k % 4), frames[k % 4], 4'b1011);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_done(15, seen, cyc);
            if (k == 4) bus.req = 4'd0;
            checks++;
            if (!seen || cyc != ((k == 0) ? 9 : 10)) begin
                failures++;
                $display("FAIL fair_spacing n=%0d got seen=%0d cycles=%0d want %0d", k, seen, cyc, (k == 0) ? 9 : 10);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.done_id !== e.id || bus.match_count !== e.cnt) begin
                    failures++;
                    $display("FAIL fair_result n=%0d got id=%0d cnt=%0d want id=%0d cnt=%0d",
                             k, bus.done_id, bus.match_count, e.id, e.cnt);
                end
            end
            $display("fairness n=%0d id=%0d cnt=%0d cycles=%0d", k, bus.done_id, bus.match_count, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_operand_latch();
        bit   seen;
        int   cyc;
        exp_t e;
        set_frame(0, 8'b10111011);
        bus.pattern = 4'b1011;
        bus.req     = 4'b0001;
        push_exp(2'd0, 8'b10111011, 4'b1011);
        repeat (3) @(negedge clk);
        bus.pattern    = 4'b0000;
        bus.frame_data = '0;
        bus.req        = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL latch_grant got grant=%b busy=%b want 0001/1", bus.grant, bus.busy);
        end
        wait_done(10, seen, cyc);
        checks++;
        if (!seen || cyc + 4 != 9) begin
            failures++;
            $display("FAIL latch_latency got seen=%0d cycle=%0d want cycle=9", seen, cyc + 4);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.done_id !== e.id || bus.match_count !== e.cnt) begin
                failures++;
                $display("FAIL latch_result got id=%0d cnt=%0d want id=%0d cnt=%0d",
                         bus.done_id, bus.match_count, e.id, e.cnt);
            end
        end
        $display("operand_latch id=%0d cnt=%0d", bus.done_id, bus.match_count);
        @(negedge clk);
    endtask

    task automatic test_mid_frame_reset();
        bit   seen;
        int   cyc;
        exp_t e;
        set_frame(1, 8'hFF);
        bus.pattern = 4'hF;
        bus.req     = 4'b0010;
        @(negedge clk);
        bus.req = 4'd0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.done_id !== 2'd0 || bus.match_count !== 4'd0) begin
            failures++;
            $display("FAIL async_reset got grant=%b busy=%b done=%b id=%0d cnt=%0d want all 0",
                     bus.grant, bus.busy, bus.done, bus.done_id, bus.match_count);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done cycle=%0d got=1 want=0", i); end
        end
        set_frame(2, 8'b10111011);
        bus.pattern = 4'b1011;
        bus.req     = 4'b0100;
        reset       = 1'b1;
        push_exp(2'd2, 8'b10111011, 4'b1011);
        @(negedge clk);
        bus.req = 4'd0;
        wait_done(20, seen, cyc);
        checks++;
        if (!seen || cyc + 1 != 9) begin
            failures++;
            $display("FAIL post_reset_latency got seen=%0d cycle=%0d want cycle=9", seen, cyc + 1);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.done_id !== e.id || bus.match_count !== e.cnt) begin
                failures++;
                $display("FAIL post_reset_result got id=%0d cnt=%0d want id=%0d cnt=%0d",
                         bus.done_id, bus.match_count, e.id, e.cnt);
            end
        end
        $display("mid_frame_reset first id=%0d cnt=%0d", bus.done_id, bus.match_count);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_frame(0, 8'hFF);
        set_frame(3, 8'h00);
        bus.pattern = 4'hF;
        bus.req     = 4'b1001;
        reset       = 1'b1;
        push_exp(2'd0, 8'hFF, 4'hF);
        @(negedge clk);
        bus.req = 4'd0;
        wait_done(20, seen, cyc);
        checks++;
        if (!seen) begin failures++; $display("FAIL rr_reset_timeout got no done want done"); end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.done_id !== e.id || bus.match_count !== e.cnt) begin
                failures++;
                $display("FAIL rr_reset_result got id=%0d cnt=%0d want id=%0d cnt=%0d",
                         bus.done_id, bus.match_count, e.id, e.cnt);
            end
        end
        $display("rr_after_reset id=%0d cnt=%0d", bus.done_id, bus.match_count);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_saturation();
        test_fairness();
        test_operand_latch();
        test_mid_frame_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
